// File: rtl/router_pkt_tx_if.sv
// Host command/payload channel plus router-side byte stream of router_pkt_tx.
// inject_err exists only when ROUTER_PKT_TX_ERR_INJECT_EN is defined.
interface router_pkt_tx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dest;
    logic [5:0] cmd_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       router_err;
    logic       pkt_valid;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       bad_cmd;
    logic       err_seen;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    logic       inject_err;
`endif

    modport master (
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
        output inject_err,
`endif
        output cmd_valid, cmd_dest, cmd_len, pl_valid, pl_data, busy, router_err,
        input  cmd_ready, pl_ready, pkt_valid, tx_data, tx_done, bad_cmd, err_seen
    );

    modport slave (
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
        input  inject_err,
`endif
        input  cmd_valid, cmd_dest, cmd_len, pl_valid, pl_data, busy, router_err,
        output cmd_ready, pl_ready, pkt_valid, tx_data, tx_done, bad_cmd, err_seen
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers a payload, then sends header/payload/parity.
// Optional ROUTER_PKT_TX_ERR_INJECT_EN adds inject_err to send an inverted parity byte.
module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic           clock,
    input  logic           reset,
    router_pkt_tx_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_GAP     = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] dest_q, dest_d;
    logic [5:0] len_q, len_d;
    logic [5:0] idx_q, idx_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [3:0] gap_q, gap_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       tx_done_q, tx_done_d;
    logic       bad_cmd_q, bad_cmd_d;
    logic       err_seen_q, err_seen_d;
    logic [7:0] mem_q [0:62];

    logic       mem_we_s;
    logic       cmd_fire_s;
    logic       last_idx_s;
    logic [5:0] idx_inc_s;
    logic [7:0] hdr_s;
    logic [7:0] parity_out_s;

    function automatic logic [7:0] par_acc(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign cmd_fire_s = bus.cmd_valid && (state_q == ST_IDLE);
    assign idx_inc_s  = idx_q + 6'd1;
    assign last_idx_s = (idx_q == (len_q - 6'd1));
    assign hdr_s      = {len_q, dest_q};

`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    logic inj_q, inj_d;

    // Capture the per-packet parity-inversion request on command acceptance.
    always_comb begin
        inj_d = inj_q;
        if (cmd_fire_s) begin
            inj_d = bus.inject_err;
        end else begin
            inj_d = inj_q;
        end
    end

    // Injection flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end

    assign parity_out_s = inj_q ? ~parity_q : parity_q;
`else
    assign parity_out_s = parity_q;
`endif

    // Next-state and next-output decode; tx_data/pkt_valid are set for the state being entered.
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        idx_d       = idx_q;
        parity_d    = parity_q;
        tx_data_d   = tx_data_q;
        pkt_valid_d = pkt_valid_q;
        gap_d       = gap_q;
        tx_done_d   = 1'b0;
        bad_cmd_d   = 1'b0;
        err_seen_d  = err_seen_q;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    dest_d     = bus.cmd_dest;
                    len_d      = bus.cmd_len;
                    parity_d   = 8'h00;
                    idx_d      = 6'd0;
                    err_seen_d = 1'b0;
                    if ((bus.cmd_dest == 2'd3) || (bus.cmd_len == 6'd0)) begin
                        bad_cmd_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.pl_valid) begin
                    mem_we_s = 1'b1;
                    parity_d = par_acc(parity_q, bus.pl_data);
                    idx_d    = idx_inc_s;
                    if (last_idx_s) begin
                        state_d     = ST_HEADER;
                        tx_data_d   = hdr_s;
                        pkt_valid_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_HEADER: begin
                if (!bus.busy) begin
                    parity_d    = par_acc(parity_q, hdr_s);
                    idx_d       = 6'd0;
                    state_d     = ST_PAYLOAD;
                    tx_data_d   = mem_q[0];
                    pkt_valid_d = 1'b1;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (!bus.busy) begin
                    if (last_idx_s) begin
                        state_d     = ST_PARITY;
                        tx_data_d   = parity_out_s;
                        pkt_valid_d = 1'b0;
                    end else begin
                        idx_d     = idx_inc_s;
                        tx_data_d = mem_q[idx_inc_s];
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PARITY: begin
                if (!bus.busy) begin
                    state_d     = ST_GAP;
                    tx_done_d   = 1'b1;
                    tx_data_d   = 8'h00;
                    pkt_valid_d = 1'b0;
                    gap_d       = 4'd0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_GAP: begin
                if (bus.router_err) begin
                    err_seen_d = 1'b1;
                end else begin
                    err_seen_d = err_seen_q;
                end
                if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                tx_data_d   = 8'h00;
                pkt_valid_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; synchronous reset abandons any packet in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dest_q      <= 2'd0;
            len_q       <= 6'd0;
            idx_q       <= 6'd0;
            parity_q    <= 8'h00;
            tx_data_q   <= 8'h00;
            pkt_valid_q <= 1'b0;
            gap_q       <= 4'd0;
            tx_done_q   <= 1'b0;
            bad_cmd_q   <= 1'b0;
            err_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            parity_q    <= parity_d;
            tx_data_q   <= tx_data_d;
            pkt_valid_q <= pkt_valid_d;
            gap_q       <= gap_d;
            tx_done_q   <= tx_done_d;
            bad_cmd_q   <= bad_cmd_d;
            err_seen_q  <= err_seen_d;
        end
    end

    // Payload buffer; every packet refills it in LOAD before PAYLOAD reads it.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= bus.pl_data;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
    assign bus.pl_ready  = (state_q == ST_LOAD);
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.bad_cmd   = bad_cmd_q;
    assign bus.err_seen  = err_seen_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed + randomized bench for router_pkt_tx; expected streams come from a packet-level model.
module tb_router_pkt_tx;
    localparam int GAP = 3;

    logic clock = 1'b0;
    logic reset;
    router_pkt_tx_if bus();

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [7:0] pay [0:62];
    int stall_n [0:64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full packet: command, payload load (optionally gapped), transmit with stalls, gap.
    task automatic send_pkt(input logic [1:0] dest, input logic [5:0] len, input logic inj,
                            input int pl_gap, input int abort_at, input logic rerr);
        logic [7:0] exp_q [$];
        logic [7:0] par;
        logic       v;
        logic       rdy;
        int         i;
        int         cyc;
        int         k;
        int         hold;
        int         tx_cyc;
        exp_q = {};
        par   = {len, dest};
        exp_q.push_back({len, dest});
        for (int j = 0; j < int'(len); j++) begin
            exp_q.push_back(pay[j]);
            par = par ^ pay[j];
        end
        exp_q.push_back(inj ? ~par : par);

        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_dest  = dest;
        bus.cmd_len   = len;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
        bus.inject_err = inj;
`endif
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        chk("err_seen_clr", bus.err_seen, 0);
        chk("pl_ready_load", bus.pl_ready, 1);

        i = 0;
        cyc = 0;
        while (i < int'(len) && cyc < 2000) begin
            v = (pl_gap == 0) || ((cyc % pl_gap) != (pl_gap - 1));
            bus.pl_valid = v;
            bus.pl_data  = pay[i];
            rdy = bus.pl_ready;
            @(negedge clock);
            if (v && rdy) i++;
            cyc++;
        end
        bus.pl_valid = 1'b0;
        chk("load_done", i, len);

        k = 0;
        hold = 0;
        tx_cyc = 0;
        while (k < int'(len) + 2 && tx_cyc < 1000) begin
            if (k == abort_at) begin
                chk("abort_byte", bus.tx_data, exp_q[k]);
                reset    = 1'b1;
                bus.busy = 1'b0;
                @(negedge clock);
                chk("abort_pkt_valid", bus.pkt_valid, 0);
                chk("abort_tx_data", bus.tx_data, 0);
                chk("abort_cmd_ready_rst", bus.cmd_ready, 0);
                reset = 1'b0;
                @(negedge clock);
                chk("abort_cmd_ready", bus.cmd_ready, 1);
                chk("abort_pl_ready", bus.pl_ready, 0);
                chk("abort_pkt_valid2", bus.pkt_valid, 0);
                return;
            end
            chk("tx_data", bus.tx_data, exp_q[k]);
            chk("pkt_valid", bus.pkt_valid, (k <= int'(len)));
            chk("tx_done_early", bus.tx_done, 0);
            if (hold < stall_n[k]) begin
                bus.busy = 1'b1;
                hold++;
            end else begin
                bus.busy = 1'b0;
                hold = 0;
                k++;
            end
            @(negedge clock);
            tx_cyc++;
        end
        bus.busy = 1'b0;
        chk("tx_complete", k, int'(len) + 2);

        chk("tx_done_pulse", bus.tx_done, 1);
        chk("gap_pkt_valid", bus.pkt_valid, 0);
        chk("gap_tx_data", bus.tx_data, 0);
        for (int g = 0; g < GAP; g++) begin
            chk("gap_cmd_ready", bus.cmd_ready, 0);
            bus.router_err = rerr && (g == 1);
            @(negedge clock);
            if (g == 0) chk("tx_done_once", bus.tx_done, 0);
        end
        bus.router_err = 1'b0;
        chk("gap_end_cmd_ready", bus.cmd_ready, 1);
        chk("err_seen", bus.err_seen, rerr);
    endtask

    task automatic bad_cmd_test(input logic [1:0] dest, input logic [5:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_dest  = dest;
        bus.cmd_len   = len;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        chk("bad_cmd_pulse", bus.bad_cmd, 1);
        chk("bad_pkt_valid", bus.pkt_valid, 0);
        chk("bad_pl_ready", bus.pl_ready, 0);
        chk("bad_cmd_ready", bus.cmd_ready, 1);
        @(negedge clock);
        chk("bad_cmd_once", bus.bad_cmd, 0);
        chk("bad_pl_ready2", bus.pl_ready, 0);
        chk("bad_pkt_valid2", bus.pkt_valid, 0);
    endtask

    initial begin
        logic [1:0] rd;
        logic [5:0] rl;
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_dest   = 2'd0;
        bus.cmd_len    = 6'd0;
        bus.pl_valid   = 1'b0;
        bus.pl_data    = 8'h00;
        bus.busy       = 1'b0;
        bus.router_err = 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
        bus.inject_err = 1'b0;
`endif
        for (int j = 0; j <= 64; j++) stall_n[j] = 0;

        @(negedge clock);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_pl_ready", bus.pl_ready, 0);
        chk("rst_pkt_valid", bus.pkt_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_tx_done", bus.tx_done, 0);
        chk("rst_bad_cmd", bus.bad_cmd, 0);
        chk("rst_err_seen", bus.err_seen, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        pay[0] = 8'h11;
        pay[1] = 8'h22;
        pay[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 1'b0, 0, -1, 1'b0);

        stall_n[0] = 2;
        stall_n[2] = 1;
        send_pkt(2'd1, 6'd3, 1'b0, 0, -1, 1'b1);
        for (int j = 0; j <= 64; j++) stall_n[j] = 0;

        bad_cmd_test(2'd3, 6'd5);
        bad_cmd_test(2'd0, 6'd0);

        for (int j = 0; j < 63; j++) pay[j] = 8'(j);
        send_pkt(2'd0, 6'd63, 1'b0, 4, -1, 1'b0);

        repeat (6) begin
            rd = 2'($urandom_range(0, 2));
            rl = 6'($urandom_range(1, 63));
            for (int j = 0; j < 63; j++) pay[j] = 8'($urandom);
            for (int j = 0; j <= 64; j++)
                stall_n[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_pkt(rd, rl, 1'b0, int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)));
        end
        for (int j = 0; j <= 64; j++) stall_n[j] = 0;

        for (int j = 0; j < 63; j++) pay[j] = 8'($urandom);
        send_pkt(2'd1, 6'd20, 1'b0, 0, 10, 1'b0);
        pay[0] = 8'h3C;
        send_pkt(2'd2, 6'd1, 1'b0, 0, -1, 1'b0);

`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
        pay[0] = 8'hA5;
        send_pkt(2'd2, 6'd1, 1'b1, 0, -1, 1'b1);
        send_pkt(2'd2, 6'd1, 1'b0, 0, -1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
